fetch_queue: RTL and testbench

- Parametrised fetch front end that replaces the fixed two-stage PC / f1-f2 / f2-d register chain.
- Generates sequential PCs and issues requests to the instruction SRAM, whose read latency is configurable.
- Tracks requests that are still in flight and buffers returned instructions in a DEPTH-entry FIFO, so decode stalls never drop fetched words.
- A redirect from decode (branch taken or jump) kills everything younger and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch entry record carried through the fetch queue.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched instructions; head is zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clear,
  input  logic                         push,
  input  cpu_pkg::fetch_entry_t        push_entry,
  input  logic                         pop,
  output cpu_pkg::fetch_entry_t        head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_ok;

  assign pop_ok = pop & (count_reg != '0);

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  assign head      = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
  assign occupancy = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited SRAM requests,
// in-flight tracking for a MEM_LAT-cycle memory and a decoupling FIFO toward decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter int              MEM_LAT  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        nrst,
  output logic                        isram_cs,
  output logic [ADDR_W-1:0]           isram_addr,
  input  logic [XLEN-1:0]             isram_dataout,
  input  logic                        redirect,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [XLEN-1:0]             deq_inst,
  output logic [XLEN-1:0]             deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_reg;
  logic            fl_valid_reg [MEM_LAT];
  logic [XLEN-1:0] fl_pc_reg    [MEM_LAT];
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;
  logic            issue;
  logic            push;
  logic            pop;
  int              inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LAT; i++) inflight += int'(fl_valid_reg[i]);
  end

  // Credits count both buffered and in-flight words, so a response always finds a free slot.
  assign issue = nrst & ~redirect & ((int'(fifo_count) + inflight) < DEPTH);

  always_ff @(posedge clk) begin
    if (!nrst)         pc_reg <= RESET_PC;
    else if (redirect) pc_reg <= redirect_pc;
    else if (issue)    pc_reg <= pc_reg + XLEN'(4);
  end

  generate
    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_flight
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!nrst || redirect) fl_valid_reg[gi] <= 1'b0;
          else                   fl_valid_reg[gi] <= issue;
          fl_pc_reg[gi] <= pc_reg;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!nrst || redirect) fl_valid_reg[gi] <= 1'b0;
          else                   fl_valid_reg[gi] <= fl_valid_reg[gi-1];
          fl_pc_reg[gi] <= fl_pc_reg[gi-1];
        end
      end
    end
  endgenerate

  assign push       = fl_valid_reg[MEM_LAT-1] & ~redirect;
  assign push_entry = '{inst: isram_dataout, pc: fl_pc_reg[MEM_LAT-1]};
  assign deq_valid  = nrst & ~redirect & (fifo_count != '0);
  assign pop        = deq_valid & deq_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head_entry),
    .occupancy  (fifo_count)
  );

  assign isram_cs   = issue;
  assign isram_addr = pc_reg[ADDR_W-1:0];
  assign deq_inst   = nrst ? head_entry.inst : '0;
  assign deq_pc     = nrst ? head_entry.pc   : '0;
  assign occupancy  = nrst ? fifo_count      : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench: two fetch_queue instances (MEM_LAT=1 and MEM_LAT=2) share all control inputs.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq_ready = 1'b1;

  logic        cs1, cs2, dv1, dv2;
  logic [15:0] addr1, addr2;
  logic [31:0] data1, data2, inst1, inst2, pc1, pc2;
  logic [2:0]  occ1, occ2;
  logic [15:0] mem1_q, mem2_a, mem2_b;

  int vectors = 0;
  int miscompares = 0;
  int cs_count;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .ADDR_W(16), .DEPTH(4), .MEM_LAT(1), .RESET_PC(32'h0)) u1 (
    .clk(clk), .nrst(nrst), .isram_cs(cs1), .isram_addr(addr1), .isram_dataout(data1),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(dv1), .deq_inst(inst1), .deq_pc(pc1), .occupancy(occ1)
  );

  fetch_queue #(.XLEN(32), .ADDR_W(16), .DEPTH(4), .MEM_LAT(2), .RESET_PC(32'h0)) u2 (
    .clk(clk), .nrst(nrst), .isram_cs(cs2), .isram_addr(addr2), .isram_dataout(data2),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(dv2), .deq_inst(inst2), .deq_pc(pc2), .occupancy(occ2)
  );

  // Memory models: the returned word equals the requested address.
  always @(posedge clk) begin
    mem1_q <= addr1;
    mem2_a <= addr2;
    mem2_b <= mem2_a;
  end
  assign data1 = {16'h0, mem1_q};
  assign data2 = {16'h0, mem2_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every sampled cycle also confirms the FIFO never holds more than DEPTH entries.
  task automatic settle();
    @(negedge clk);
    chk("occ1_le_depth", {31'h0, occ1 <= 3'd4}, 32'h1);
    chk("occ2_le_depth", {31'h0, occ2 <= 3'd4}, 32'h1);
  endtask

  // Leaves the bench just inside cycle 0, the first cycle with nrst=1.
  task automatic do_reset(input logic dr);
    tick();
    nrst = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = dr;
    settle();
    chk("rst_cs1",  {31'h0, cs1}, 32'h0);
    chk("rst_dv1",  {31'h0, dv1}, 32'h0);
    chk("rst_occ1", {29'h0, occ1}, 32'h0);
    chk("rst_pc1",  pc1, 32'h0);
    chk("rst_inst1", inst1, 32'h0);
    chk("rst_cs2",  {31'h0, cs2}, 32'h0);
    tick();
    settle();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    // 1: free run, MEM_LAT=1
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      settle();
      chk($sformatf("t1_cs_c%0d", k), {31'h0, cs1}, 32'h1);
      chk($sformatf("t1_addr_c%0d", k), {16'h0, addr1}, 32'(4 * k));
      chk($sformatf("t1_dv_c%0d", k), {31'h0, dv1}, (k >= 2) ? 32'h1 : 32'h0);
      chk($sformatf("t1_pc_c%0d", k), pc1, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
      chk($sformatf("t1_inst_c%0d", k), inst1, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
      chk($sformatf("t1_occ_c%0d", k), {29'h0, occ1}, (k >= 2) ? 32'h1 : 32'h0);
    end

    // 2: decode stalled for 10 cycles, then drains
    do_reset(1'b0);
    cs_count = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      settle();
      if (cs1) cs_count++;
    end
    chk("t2_req_count", 32'(cs_count), 32'd4);
    chk("t2_occ_full", {29'h0, occ1}, 32'd4);
    chk("t2_cs_idle", {31'h0, cs1}, 32'h0);
    chk("t2_head_pc", pc1, 32'h0);
    for (int k = 10; k < 16; k++) begin
      tick();
      deq_ready = 1'b1;
      settle();
      chk($sformatf("t2_dv_c%0d", k), {31'h0, dv1}, 32'h1);
      chk($sformatf("t2_pc_c%0d", k), pc1, 32'(4 * (k - 10)));
      chk($sformatf("t2_cs_c%0d", k), {31'h0, cs1}, (k >= 11) ? 32'h1 : 32'h0);
    end

    // 3: redirect with 3 buffered and 1 in flight
    do_reset(1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      settle();
    end
    tick();
    redirect = 1'b1; redirect_pc = 32'h100; deq_ready = 1'b1;
    settle();
    chk("t3_occ_before", {29'h0, occ1}, 32'd3);
    chk("t3_dv_redirect", {31'h0, dv1}, 32'h0);
    chk("t3_cs_redirect", {31'h0, cs1}, 32'h0);
    tick();
    redirect = 1'b0;
    settle();
    chk("t3_occ_cleared", {29'h0, occ1}, 32'h0);
    chk("t3_cs_restart", {31'h0, cs1}, 32'h1);
    chk("t3_addr_restart", {16'h0, addr1}, 32'h100);
    chk("t3_dv_c5", {31'h0, dv1}, 32'h0);
    tick(); settle();
    chk("t3_addr_c6", {16'h0, addr1}, 32'h104);
    chk("t3_dv_c6", {31'h0, dv1}, 32'h0);
    tick(); settle();
    chk("t3_dv_c7", {31'h0, dv1}, 32'h1);
    chk("t3_pc_c7", pc1, 32'h100);
    chk("t3_inst_c7", inst1, 32'h100);
    tick(); settle();
    chk("t3_pc_c8", pc1, 32'h104);

    // 4: MEM_LAT=2, back-to-back redirects
    do_reset(1'b1);
    for (int k = 1; k < 3; k++) begin
      tick();
      settle();
    end
    chk("t4_cs2_c2", {31'h0, cs2}, 32'h1);
    chk("t4_addr2_c2", {16'h0, addr2}, 32'h8);
    chk("t4_dv2_c2", {31'h0, dv2}, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    settle();
    chk("t4_cs2_c3", {31'h0, cs2}, 32'h0);
    chk("t4_dv2_c3", {31'h0, dv2}, 32'h0);
    tick();
    redirect_pc = 32'h300;
    settle();
    chk("t4_cs2_c4", {31'h0, cs2}, 32'h0);
    chk("t4_dv2_c4", {31'h0, dv2}, 32'h0);
    chk("t4_occ2_c4", {29'h0, occ2}, 32'h0);
    tick();
    redirect = 1'b0;
    settle();
    chk("t4_cs2_c5", {31'h0, cs2}, 32'h1);
    chk("t4_addr2_c5", {16'h0, addr2}, 32'h300);
    for (int k = 6; k < 11; k++) begin
      tick();
      settle();
      chk($sformatf("t4_dv2_c%0d", k), {31'h0, dv2}, (k >= 8) ? 32'h1 : 32'h0);
      chk($sformatf("t4_pc2_c%0d", k), pc2, (k >= 8) ? 32'(32'h300 + 4 * (k - 8)) : 32'h0);
    end

    // 5: one-cycle reset pulse with the FIFO full
    do_reset(1'b0);
    for (int k = 1; k < 6; k++) begin
      tick();
      settle();
    end
    chk("t5_occ_full", {29'h0, occ1}, 32'd4);
    tick();
    nrst = 1'b0;
    settle();
    chk("t5_dv_in_rst", {31'h0, dv1}, 32'h0);
    chk("t5_cs_in_rst", {31'h0, cs1}, 32'h0);
    tick();
    nrst = 1'b1;
    settle();
    chk("t5_occ_after", {29'h0, occ1}, 32'h0);
    chk("t5_dv_after", {31'h0, dv1}, 32'h0);
    chk("t5_cs_after", {31'h0, cs1}, 32'h1);
    chk("t5_addr_after", {16'h0, addr1}, 32'h0);
    tick(); settle();
    chk("t5_addr_c8", {16'h0, addr1}, 32'h4);
    tick(); settle();
    chk("t5_dv_c9", {31'h0, dv1}, 32'h1);
    chk("t5_pc_c9", pc1, 32'h0);

    // 6: PC wrap at the top of the address space
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    settle();
    chk("t6_cs_c0", {31'h0, cs1}, 32'h0);
    tick();
    redirect = 1'b0;
    settle();
    chk("t6_addr_c1", {16'h0, addr1}, 32'h0000_FFF8);
    chk("t6_cs_c1", {31'h0, cs1}, 32'h1);
    tick(); settle();
    chk("t6_addr_c2", {16'h0, addr1}, 32'h0000_FFFC);
    tick(); settle();
    chk("t6_addr_c3", {16'h0, addr1}, 32'h0);
    chk("t6_dv_c3", {31'h0, dv1}, 32'h1);
    chk("t6_pc_c3", pc1, 32'hFFFF_FFF8);
    chk("t6_inst_c3", inst1, 32'h0000_FFF8);
    tick(); settle();
    chk("t6_pc_c4", pc1, 32'hFFFF_FFFC);
    tick(); settle();
    chk("t6_pc_c5", pc1, 32'h0);
    chk("t6_inst_c5", inst1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
